seq_detect_param: RTL and testbench
===================================

# seq_detect_param

Parametrised synchronous sequence detector for the lab-board designs: generalises the fixed 2-input, 2-state-bit textbook detector into a block with configurable symbol width, pattern length, run-time loadable pattern and selectable overlap mode. Consumes one symbol per `sym_valid` cycle. Raises a registered one-cycle `z` pulse when the last DEPTH accepted symbols equal the stored pattern. Sits between the debounced switch/input sampler and the LED/seven-segment output logic.

## Interface
- `SYM_W`, 2, symbol width in bits (x2..x1 generalised), ≥1
- `DEPTH`, 4, pattern length in symbols, ≥1
- `PAT_INIT`, 8'h78, reset pattern, SYM_W*DEPTH bits; default = 00,10,11,01 in arrival order
- `CNT_W`, 8, match counter width
- `clk`  in  1  system clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `sym_valid`  in  1  sample `sym_in` this cycle
- `sym_in`  in  SYM_W  input symbol
- `overlap`  in  1  1 = overlapping matches allowed, 0 = restart after a match
- `pat_load`  in  1  load `pat_in` into pattern register
- `pat_in`  in  SYM_W*DEPTH  new pattern; slice k (`k*SYM_W +: SYM_W`) = k-th symbol in arrival order, k=0 first
- `cnt_clr`  in  1  clear match counter
- `z`  out  1  match pulse, registered
- `fill`  out  clog2(DEPTH+1)  number of valid symbols in history, saturates at DEPTH
- `match_cnt`  out  CNT_W  saturating match count (see Configuration)

## Operation
- State: pattern register `pat`, history shift register `hist` (DEPTH symbols), `fill`, `z`, `match_cnt`.
- Reset: `pat`=PAT_INIT, `hist`=0, `fill`=0, `z`=0, `match_cnt`=0.
- `pat_load`=1 has priority over `sym_valid`.
  - `pat`←`pat_in`, `hist`←0, `fill`←0, `z`←0.
  - Any symbol presented that cycle is discarded.
  - `match_cnt` is unaffected.
- `sym_valid`=1 without `pat_load`:
  - Shift `sym_in` in as newest symbol; oldest symbol drops out.
  - `fill`←min(fill+1, DEPTH).
  - Match condition: new `fill`==DEPTH and shifted history equals `pat` symbol-for-symbol (oldest vs slice 0).
  - On match: `z`←1. If `overlap`=0, `fill`←0; history contents are then irrelevant until refilled. If `overlap`=1, `fill` stays DEPTH.
- `sym_valid`=0: history and `fill` hold; `z`←0.
- `overlap` is sampled on the same edge as the matching symbol.
- Comparison is exact on all SYM_W bits; there are no don't-care symbols.
- DEPTH=1: every accepted symbol equal to `pat` matches; `fill` toggles 0/1 only when `overlap`=0.

## Timing
- One symbol per cycle max; no back-pressure.
- Latency: `z` is high in the cycle after the edge that samples the final pattern symbol. Pulse width is one cycle.
- Back-to-back matches in consecutive cycles produce consecutive `z` high cycles.
  - Only possible when `overlap`=1, or when DEPTH=1.
- `fill` and `match_cnt` update on the same edge as `z`.
- `rst` mid-sequence: next cycle all state at reset values, including `pat`=PAT_INIT. No pending match survives.
- `pat_load` on the same edge as a would-be match: no match, `z`=0.

## Configuration
- `SEQ_DETECT_CNT_EN` defined:
  - `match_cnt` increments by 1 on every edge that sets `z`.
  - Saturates at 2^CNT_W−1.
  - `cnt_clr` sets it to 0 and takes priority over a simultaneous increment.
- `SEQ_DETECT_CNT_EN` undefined: counter logic absent; `match_cnt` tied to 0; `cnt_clr` ignored.

## Test plan
- Reset, default pattern, `overlap`=0; feed 00,10,11,01 on consecutive cycles → `z`=1 only in cycle after 01; `fill` 1,2,3,4→0; `match_cnt`=1.
- Default pattern; feed 00,10,11,00,10,11,01 → no `z` after first 00 repeat, single `z` after final 01; `match_cnt`=1.
- `pat_load` with 8'b00_00_00_00; feed seven 00 symbols, `overlap`=1 → `z` high on cycles after symbols 4,5,6,7 (4 pulses). Same stimulus with `overlap`=0 → pulses after symbols 4 only (cycle 8 needs 4 more) → `match_cnt`=1.
- Feed 00,10 then assert `rst` one cycle, then 11,01 → no `z`; `fill`=2 after reset sequence.
- `pat_load` asserted together with `sym_valid` carrying the final 01 of a matching run → `z`=0, `fill`=0, new pattern active.
- With `SEQ_DETECT_CNT_EN`, CNT_W=2: force 5 matches → `match_cnt` 1,2,3,3,3. Then `cnt_clr` in the same cycle as a matching symbol → `match_cnt`=0 while `z`=1.

Source files
------------

// File: rtl/seq_detect_param.sv
// rtl/seq_detect_param.sv - parametrised symbol sequence detector with loadable pattern and overlap mode
// Optional match counter enabled by defining SEQ_DETECT_CNT_EN.
module seq_detect_param #(
    parameter int                       SYM_W    = 2,
    parameter int                       DEPTH    = 4,
    parameter logic [SYM_W*DEPTH-1:0]   PAT_INIT = 8'h78,
    parameter int                       CNT_W    = 8,
    localparam int                      FILL_W   = $clog2(DEPTH + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        sym_valid,
    input  logic [SYM_W-1:0]            sym_in,
    input  logic                        overlap,
    input  logic                        pat_load,
    input  logic [SYM_W*DEPTH-1:0]      pat_in,
    input  logic                        cnt_clr,
    output logic                        z,
    output logic [FILL_W-1:0]           fill,
    output logic [CNT_W-1:0]            match_cnt
);

    localparam int                PW      = SYM_W * DEPTH;
    localparam logic [FILL_W-1:0] DEPTH_F = FILL_W'(DEPTH);

    logic [PW-1:0]     r_pat;
    logic [PW-1:0]     r_hist;
    logic [FILL_W-1:0] r_fill;
    logic              r_z;

    logic [PW-1:0]     w_hist_next;
    logic [FILL_W-1:0] w_fill_inc;
    logic              w_match;

    // Slice 0 holds the oldest symbol so the history lines up with pat slice order.
    generate
        if (DEPTH == 1) begin : g_single
            assign w_hist_next = sym_in;
        end else begin : g_multi
            assign w_hist_next = {sym_in, r_hist[PW-1:SYM_W]};
        end
    endgenerate

    assign w_fill_inc = (r_fill == DEPTH_F) ? DEPTH_F : r_fill + 1'b1;
    assign w_match    = sym_valid && !pat_load && (w_fill_inc == DEPTH_F)
                        && (w_hist_next == r_pat);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pat  <= PAT_INIT;
            r_hist <= '0;
            r_fill <= '0;
            r_z    <= 1'b0;
        end else if (pat_load) begin
            r_pat  <= pat_in;
            r_hist <= '0;
            r_fill <= '0;
            r_z    <= 1'b0;
        end else if (sym_valid) begin
            r_hist <= w_hist_next;
            r_z    <= w_match;
            r_fill <= (w_match && !overlap) ? '0 : w_fill_inc;
        end else begin
            r_z    <= 1'b0;
        end
    end

    assign z    = r_z;
    assign fill = r_fill;

`ifdef SEQ_DETECT_CNT_EN
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            r_cnt <= '0;
        end else if (w_match && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign match_cnt = r_cnt;
`else
    logic w_unused_cnt_clr;

    assign w_unused_cnt_clr = cnt_clr;
    assign match_cnt        = '0;
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// tb/tb_seq_detect_param.sv - randomized and directed check of seq_detect_param against a queue-based model
module tb_seq_detect_param;

    localparam int SYM_W = 2;
    localparam int DEPTH = 4;
    localparam int CNT_W = 2;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             sym_valid;
    logic [1:0]       sym_in;
    logic             overlap;
    logic             pat_load;
    logic [7:0]       pat_in;
    logic             cnt_clr;
    logic             z;
    logic [2:0]       fill;
    logic [CNT_W-1:0] match_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: accepted symbols since last restart, oldest first.
    logic [1:0] mq[$];
    logic [1:0] m_pat[DEPTH];
    int         m_z;
    int         m_cnt;

    seq_detect_param #(
        .SYM_W(SYM_W), .DEPTH(DEPTH), .PAT_INIT(8'h78), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .sym_valid(sym_valid), .sym_in(sym_in),
        .overlap(overlap), .pat_load(pat_load), .pat_in(pat_in),
        .cnt_clr(cnt_clr), .z(z), .fill(fill), .match_cnt(match_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_pat(input logic [7:0] p);
        for (int k = 0; k < DEPTH; k++) m_pat[k] = p[k*SYM_W +: SYM_W];
    endtask

    task automatic model(input logic v, input logic [1:0] s, input logic ov,
                         input logic ld, input logic [7:0] pi, input logic clr,
                         input logic r);
        bit hit;
        hit = 0;
        if (r) begin
            mq.delete();
            set_pat(8'h78);
            m_z   = 0;
            m_cnt = 0;
            return;
        end
        if (ld) begin
            mq.delete();
            set_pat(pi);
        end else if (v) begin
            mq.push_back(s);
            if (mq.size() > DEPTH) void'(mq.pop_front());
            if (mq.size() == DEPTH) begin
                hit = 1;
                for (int k = 0; k < DEPTH; k++) if (mq[k] != m_pat[k]) hit = 0;
            end
            if (hit && !ov) mq.delete();
        end
        m_z = hit;
`ifdef SEQ_DETECT_CNT_EN
        if (clr) m_cnt = 0;
        else if (hit && m_cnt < CMAX) m_cnt++;
`else
        m_cnt = 0;
`endif
    endtask

    task automatic step(input logic v, input logic [1:0] s, input logic ov,
                        input logic ld, input logic [7:0] pi, input logic clr,
                        input logic r);
        sym_valid = v; sym_in = s; overlap = ov; pat_load = ld;
        pat_in = pi; cnt_clr = clr; rst = r;
        @(posedge clk);
        model(v, s, ov, ld, pi, clr, r);
        #1;
        check("z", int'(z), m_z);
        check("fill", int'(fill), mq.size());
        check("match_cnt", int'(match_cnt), m_cnt);
    endtask

    task automatic feed(input logic [1:0] s, input logic ov);
        step(1'b1, s, ov, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b0, 2'b00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    logic [1:0] seq_a[4] = '{2'b00, 2'b10, 2'b11, 2'b01};
    logic [1:0] seq_b[7] = '{2'b00, 2'b10, 2'b11, 2'b00, 2'b10, 2'b11, 2'b01};

    initial begin
        set_pat(8'h78);
        m_z = 0; m_cnt = 0;
        do_reset();
        do_reset();
        check("reset_fill", int'(fill), 0);

        // Default pattern, non-overlapping.
        for (int i = 0; i < 4; i++) feed(seq_a[i], 1'b0);
        check("t1_z", int'(z), 1);
        check("t1_fill", int'(fill), 0);
`ifdef SEQ_DETECT_CNT_EN
        check("t1_cnt", int'(match_cnt), 1);
`endif

        do_reset();
        for (int i = 0; i < 7; i++) feed(seq_b[i], 1'b0);
        check("t2_z", int'(z), 1);

        // All-zero pattern, overlap then restart mode.
        step(1'b0, 2'b00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) feed(2'b00, 1'b1);
        step(1'b0, 2'b00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) feed(2'b00, 1'b0);
        check("t3_fill", int'(fill), 3);

        // Reset mid-sequence.
        do_reset();
        feed(2'b00, 1'b0); feed(2'b10, 1'b0);
        do_reset();
        feed(2'b11, 1'b0); feed(2'b01, 1'b0);
        check("t4_fill", int'(fill), 2);
        check("t4_z", int'(z), 0);

        // Pattern load colliding with the completing symbol.
        do_reset();
        for (int i = 0; i < 3; i++) feed(seq_a[i], 1'b0);
        step(1'b1, 2'b01, 1'b0, 1'b1, 8'hE4, 1'b0, 1'b0);
        check("t5_z", int'(z), 0);
        for (int i = 0; i < 4; i++) feed(2'(i), 1'b0);
        check("t5_newpat", int'(z), 1);

        // Counter saturation and clear on a matching edge.
        do_reset();
        for (int m = 0; m < 5; m++)
            for (int i = 0; i < 4; i++) feed(seq_a[i], 1'b0);
        for (int i = 0; i < 3; i++) feed(seq_a[i], 1'b0);
        step(1'b1, 2'b01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        check("t6_z", int'(z), 1);
        check("t6_cnt", int'(match_cnt), 0);

        // Randomized traffic biased toward completing the current pattern.
        for (int n = 0; n < 3000; n++) begin
            int          r;
            logic [1:0]  s;
            logic [7:0]  p;
            r = int'($urandom_range(0, 99));
            s = (r < 60) ? m_pat[mq.size() % DEPTH] : 2'($urandom);
            p = 8'($urandom);
            if ($urandom_range(0, 3) == 0) p = p & 8'h55;
            step(($urandom_range(0, 4) != 0), s, 1'($urandom),
                 ($urandom_range(0, 80) == 0), p,
                 ($urandom_range(0, 40) == 0), ($urandom_range(0, 300) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
